// File: rtl/prbs_range_gen.sv
// Parametrised Fibonacci-LFSR source that hands out values below a runtime limit via rejection sampling.
// Optional macro PRBS_REJECT_CNT_EN enables the saturating rejection counter on reject_cnt.
module prbs_range_gen #(
    parameter int unsigned      WIDTH     = 7,
    parameter logic [WIDTH-1:0] TAPS      = 7'b1100000,
    parameter int unsigned      OUT_W     = 7,
    parameter int unsigned      MAX_TRIES = 15
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic [WIDTH-1:0] seed,
    input  logic             seed_load,
    input  logic             run_en,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic [WIDTH-1:0] rnd,
    output logic [OUT_W-1:0] value,
    output logic             valid,
    output logic             busy,
    output logic             fallback,
    output logic [15:0]      reject_cnt
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic {
        IDLE,
        DRAW
    } state_t;

    state_t           state;
    logic [TRY_W-1:0] tries;
    logic [OUT_W-1:0] limit_q;

    logic [WIDTH-1:0] rnd_step;
    logic [WIDTH-1:0] seed_safe;
    logic [OUT_W-1:0] candidate;
    logic             accept;
    logic             last_try;

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        rnd_step = {rnd[WIDTH-2:0], ^(rnd & TAPS)};
        if (rnd == '0) begin
            rnd_step = WIDTH'(1);
        end
    end

    // An all-zero seed would park the LFSR forever, so it is replaced by 1.
    assign seed_safe = (seed == '0) ? WIDTH'(1) : seed;
    assign candidate = rnd[OUT_W-1:0];
    assign accept    = (candidate < limit_q);
    assign last_try  = (tries == LAST_TRY);

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            rnd      <= seed_safe;
            value    <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            fallback <= 1'b0;
            state    <= IDLE;
            tries    <= '0;
            limit_q  <= '0;
        end else begin
            // The LFSR always advances in DRAW so a draw never stalls with run_en low.
            if (seed_load) begin
                rnd <= seed_safe;
            end else if (run_en || state == DRAW) begin
                rnd <= rnd_step;
            end

            valid    <= 1'b0;
            fallback <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        if (limit != '0) begin
                            limit_q <= limit;
                            tries   <= '0;
                            busy    <= 1'b1;
                            state   <= DRAW;
                        end else begin
                            value    <= '0;
                            valid    <= 1'b1;
                            fallback <= 1'b1;
                        end
                    end
                end
                DRAW: begin
                    if (accept) begin
                        value <= candidate;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (last_try) begin
                        value    <= '0;
                        valid    <= 1'b1;
                        fallback <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRBS_REJECT_CNT_EN
    logic [15:0] reject_q;

    // Every rejected DRAW evaluation counts, including the one that triggers the fallback.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            reject_q <= '0;
        end else if (state == DRAW && !accept && reject_q != 16'hFFFF) begin
            reject_q <= reject_q + 16'd1;
        end
    end

    assign reject_cnt = reject_q;
`else
    assign reject_cnt = '0;
`endif

endmodule
